// File: rtl/halut_pkg.sv
// Shared sizing for the HALUT decoder slice: codebook geometry and derived widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package halut_pkg;

   localparam int unsigned K             = 16;
   localparam int unsigned C             = 32;
   localparam int unsigned DataTypeWidth = 16;

   localparam int unsigned TreeDepth     = $clog2(K);
   localparam int unsigned CAddrWidth    = $clog2(C);
   localparam int unsigned AccWidth      = DataTypeWidth + CAddrWidth;
   localparam int unsigned LutAddrWidth  = CAddrWidth + TreeDepth;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } dec_state_e;

endpackage

// File: rtl/halut_decoder_scm.sv
// LUT storage: C*K signed entries, synchronous write port, combinational read port.
// Latency: read is same-cycle; a write becomes visible on the cycle after we_i.
// Backpressure: none; one read and one write accepted every cycle.
module halut_decoder_scm #(
   parameter int unsigned K             = 16,
   parameter int unsigned C             = 32,
   parameter int unsigned DataTypeWidth = 16,
   localparam int unsigned TreeDepth    = $clog2(K),
   localparam int unsigned CAddrWidth   = $clog2(C),
   localparam int unsigned LutAddrWidth = CAddrWidth + TreeDepth
) (
   input  logic                     clk_i,
   input  logic [LutAddrWidth-1:0]  waddr_i,
   input  logic [DataTypeWidth-1:0] wdata_i,
   input  logic                     we_i,
   input  logic [LutAddrWidth-1:0]  raddr_i,
   output logic [DataTypeWidth-1:0] rdata_o
);

   // Entries are loaded by software before use, so the array carries no reset.
   logic [DataTypeWidth-1:0] mem_q [C*K];

   // Write commits at the clock edge; a same-cycle read therefore sees the old entry.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/halut_decoder.sv
// HALUT decoder: looks up one LUT entry per (c_addr, k_addr) and sums C entries into a row result.
// Latency: last valid_i of a row at cycle t -> valid_o pulse with result_o at t+2.
// Backpressure: none; accepts one entry per cycle, rows back-to-back, no ready signal.
module halut_decoder #(
   parameter int unsigned K             = halut_pkg::K,
   parameter int unsigned C             = halut_pkg::C,
   parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
   localparam int unsigned TreeDepth    = $clog2(K),
   localparam int unsigned CAddrWidth   = $clog2(C),
   localparam int unsigned AccWidth     = DataTypeWidth + CAddrWidth,
   localparam int unsigned LutAddrWidth = CAddrWidth + TreeDepth
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [LutAddrWidth-1:0]  waddr_i,
   input  logic [DataTypeWidth-1:0] wdata_i,
   input  logic                     we_i,
   input  logic                     decoder_i,
   input  logic [CAddrWidth-1:0]    c_addr_i,
   input  logic [TreeDepth-1:0]     k_addr_i,
   input  logic                     valid_i,
   output logic [AccWidth-1:0]      result_o,
   output logic                     valid_o,
   output logic                     busy_o
);

   import halut_pkg::*;

   dec_state_e state_q, state_d;
   logic       flush;
   logic       accept;

   // Stage 1: registered encoder output
   logic                  in_vld_q;
   logic [CAddrWidth-1:0] in_c_q;
   logic [TreeDepth-1:0]  in_k_q;

   // Stage 2: LUT read and accumulate
   logic [DataTypeWidth-1:0] lut_rdata;
   logic [AccWidth-1:0]      entry_sext;
   logic [AccWidth-1:0]      acc_sum;
   logic [AccWidth-1:0]      acc_q;
   logic [CAddrWidth-1:0]    cnt_q;
   logic [AccWidth-1:0]      result_q;
   logic                     result_vld_q;
   logic                     s2_fire;
   logic                     row_end;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; leaving ACCUM raises flush so the partial row is dropped in the same cycle.
   always_comb begin
      state_d = state_q;
      flush   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (decoder_i) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (!decoder_i) begin
               state_d = IDLE;
               flush   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Encoder valids only count while accumulating; in IDLE they are ignored.
   assign accept = (state_q == ACCUM) && decoder_i;

   // Stage-1 capture of the encoder output; cleared on flush.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_vld_q <= 1'b0;
         in_c_q   <= '0;
         in_k_q   <= '0;
      end else if (flush) begin
         in_vld_q <= 1'b0;
         in_c_q   <= '0;
         in_k_q   <= '0;
      end else begin
         in_vld_q <= valid_i && accept;
         in_c_q   <= c_addr_i;
         in_k_q   <= k_addr_i;
      end
   end

   halut_decoder_scm #(
      .K             (K),
      .C             (C),
      .DataTypeWidth (DataTypeWidth)
   ) i_scm (
      .clk_i   (clk_i),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .we_i    (we_i),
      .raddr_i ({in_c_q, in_k_q}),
      .rdata_o (lut_rdata)
   );

   // The AccWidth headroom of CAddrWidth bits is exactly enough for C full-scale entries.
   assign entry_sext = {{CAddrWidth{lut_rdata[DataTypeWidth-1]}}, lut_rdata};
   assign acc_sum    = acc_q + entry_sext;

   // A flush in the same cycle as the row's last entry wins: no result is produced.
   assign s2_fire = in_vld_q && !flush;
   assign row_end = s2_fire && (cnt_q == CAddrWidth'(C - 1));

   // Accumulate entries; on the C-th entry publish the sum and restart the row.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         result_q     <= '0;
         result_vld_q <= 1'b0;
      end else begin
         result_vld_q <= row_end;
         if (flush) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else if (row_end) begin
            result_q <= acc_sum;
            acc_q    <= '0;
            cnt_q    <= '0;
         end else if (s2_fire) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + CAddrWidth'(1);
         end
      end
   end

   assign result_o = result_q;
   assign valid_o  = result_vld_q;
   assign busy_o   = (cnt_q != '0) || in_vld_q;

endmodule
